// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_sb : 2-read/1-write register file with per-register busy bits.   |
// | The registers are self-cleared after reset. Reads bypass same-cycle      |
// | writes.                                                                  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_register_no,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] A_add,
    input  logic [ADDR_W-1:0] B_add,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              A_busy,
    output logic              B_busy,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_no,
    output logic              ready
);

    localparam int                c_DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = '1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]   r_regs [c_DEPTH];
    logic [c_DEPTH-1:0]  r_busy;

    logic w_run;
    logic w_wr_ok;
    logic w_claim_ok;
    logic w_a_ok;
    logic w_b_ok;
    logic w_a_wr_hit;
    logic w_b_wr_hit;
    logic w_a_cl_hit;
    logic w_b_cl_hit;

    assign w_run      = (r_state == S_RUN);
    // Address 0 is treated as unwritable and unclaimable when hardwired.
    assign w_wr_ok    = w_run && wr    && !((R0_ZERO != 0) && (wr_register_no == '0));
    assign w_claim_ok = w_run && claim && !((R0_ZERO != 0) && (claim_no == '0));
    assign w_a_ok     = w_run && !((R0_ZERO != 0) && (A_add == '0));
    assign w_b_ok     = w_run && !((R0_ZERO != 0) && (B_add == '0));

    assign w_a_wr_hit = w_wr_ok    && (wr_register_no == A_add);
    assign w_b_wr_hit = w_wr_ok    && (wr_register_no == B_add);
    assign w_a_cl_hit = w_claim_ok && (claim_no == A_add);
    assign w_b_cl_hit = w_claim_ok && (claim_no == B_add);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Storage has no reset; the INIT sweep zeroes it one entry per edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_INIT) begin
                r_regs[r_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_regs[wr_register_no] <= wr_data;
            end
        end
    end

    // A claim is applied after the write-clear so a new producer wins.
    always_ff @(posedge clock) begin
        if (reset || !w_run) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_busy[wr_register_no] <= 1'b0;
            end
            if (w_claim_ok) begin
                r_busy[claim_no] <= 1'b1;
            end
        end
    end

    always_comb begin
        A = '0;
        if (w_a_wr_hit) begin
            A = wr_data;
        end else if (w_a_ok) begin
            A = r_regs[A_add];
        end
    end

    always_comb begin
        B = '0;
        if (w_b_wr_hit) begin
            B = wr_data;
        end else if (w_b_ok) begin
            B = r_regs[B_add];
        end
    end

    assign A_busy = w_a_ok && r_busy[A_add] && !(w_a_wr_hit && !w_a_cl_hit);
    assign B_busy = w_b_ok && r_busy[B_add] && !(w_b_wr_hit && !w_b_cl_hit);
    assign ready  = w_run;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_sb : scoreboard bench for regfile_sb with a reference model.  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

    logic        clock;
    logic        reset;
    logic        wr;
    logic [4:0]  wr_register_no;
    logic [31:0] wr_data;
    logic [4:0]  A_add;
    logic [4:0]  B_add;
    logic [31:0] A;
    logic [31:0] B;
    logic        A_busy;
    logic        B_busy;
    logic        claim;
    logic [4:0]  claim_no;
    logic        ready;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr             (wr),
        .wr_register_no (wr_register_no),
        .wr_data        (wr_data),
        .A_add          (A_add),
        .B_add          (B_add),
        .A              (A),
        .B              (B),
        .A_busy         (A_busy),
        .B_busy         (B_busy),
        .claim          (claim),
        .claim_no       (claim_no),
        .ready          (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ab;
        logic        bb;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_run   = 1'b0;
    int          m_done  = 0;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    // Monitor: whatever the stimulus announced for this cycle is checked here.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready",  {31'd0, ready},  {31'd0, e.rdy});
            chk("A",      A,               e.a);
            chk("B",      B,               e.b);
            chk("A_busy", {31'd0, A_busy}, {31'd0, e.ab});
            chk("B_busy", {31'd0, B_busy}, {31'd0, e.bb});
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] ad, input logic w,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (!m_run || ad == 5'd0) return 32'd0;
        if (w && wa == ad) return wd;
        return m_mem[ad];
    endfunction

    function automatic logic m_bsy(input logic [4:0] ad, input logic w, input logic [4:0] wa,
                                   input logic cl, input logic [4:0] cn);
        if (!m_run || ad == 5'd0) return 1'b0;
        if (w && wa == ad && !(cl && cn == ad)) return 1'b0;
        return m_busy[ad];
    endfunction

    task automatic step(input logic rst, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] aa, input logic [4:0] ba,
                        input logic cl, input logic [4:0] cn);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; wr = w; wr_register_no = wa; wr_data = wd;
        A_add = aa; B_add = ba; claim = cl; claim_no = cn;
        if (m_valid) begin
            e.a   = m_read(aa, w, wa, wd);
            e.b   = m_read(ba, w, wa, wd);
            e.ab  = m_bsy(aa, w, wa, cl, cn);
            e.bb  = m_bsy(ba, w, wa, cl, cn);
            e.rdy = m_run;
            exp_q.push_back(e);
        end
        // Advance the model to the state after the coming edge.
        if (rst) begin
            m_run = 1'b0; m_done = 0; m_valid = 1'b1;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_mem[m_done] = 32'd0;
            m_done++;
            if (m_done == 32) m_run = 1'b1;
        end else begin
            if (w && wa != 5'd0) begin
                m_mem[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (cl && cn != 5'd0) m_busy[cn] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] aa, input logic [4:0] ba);
        step(1'b0, 1'b0, 5'd0, 32'd0, aa, ba, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; wr_register_no = '0; wr_data = '0;
        A_add = '0; B_add = '0; claim = 1'b0; claim_no = '0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'd0; m_busy[i] = 1'b0;
        end

        repeat (3) step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);

        // INIT sweep with writes and claims that must be ignored.
        step(1'b0, 1'b1, 5'd3, 32'h0000_AAAA, 5'd3, 5'd4, 1'b1, 5'd4);
        step(1'b0, 1'b1, 5'd3, 32'h0000_BBBB, 5'd3, 5'd31, 1'b1, 5'd3);
        for (int i = 2; i < 32; i++) idle(5'(i), 5'd3);
        for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

        // Same-cycle bypass, then the stored value.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6, 1'b0, 5'd0);
        idle(5'd5, 5'd5);

        // Hardwired zero register.
        step(1'b0, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b1, 5'd0);
        idle(5'd0, 5'd0);

        // Claim, clearing write, and claim winning over a same-cycle write.
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7);
        step(1'b0, 1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd7, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h0000_0066, 5'd7, 5'd7, 1'b1, 5'd7);
        idle(5'd7, 5'd7);

        // Reset mid-run with r9 written and busy.
        step(1'b0, 1'b1, 5'd9, 32'h0000_00FF, 5'd9, 5'd9, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9);
        step(1'b1, 1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd9, 1'b1, 5'd9);
        for (int i = 0; i < 33; i++) idle(5'd9, 5'd7);

        // Randomized traffic, with addresses biased toward collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0]  wa, aa, ba, cn;
            logic [31:0] wd;
            logic        rst;
            wa  = 5'($urandom_range(0, 31));
            cn  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            aa  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ba  = ($urandom_range(0, 2) == 0) ? cn : 5'($urandom_range(0, 31));
            wd  = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step(rst, 1'($urandom_range(0, 1)), wa, wd, aa, ba, 1'($urandom_range(0, 2) == 0), cn);
        end

        idle(5'd0, 5'd0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, giving the register address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL take parameter R0_ZERO, default 1; when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset, sampled on the rising edge of clock.
REQ-006 wr  in  1  write enable.
REQ-007 wr_register_no  in  ADDR_W  write address.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 A_add, B_add  in  ADDR_W each  read addresses for ports A and B.
REQ-010 A, B  out  DATA_W each  combinational read data.
REQ-011 A_busy, B_busy  out  1 each  combinational scoreboard pending flag of the addressed register.
REQ-012 claim  in  1  mark a register as pending (a producer has been issued).
REQ-013 claim_no  in  ADDR_W  register to mark pending.
REQ-014 ready  out  1  initialisation complete; the block accepts writes and claims.

Function
REQ-015 The block SHALL implement two states, INIT and RUN, plus a clear counter cnt of ADDR_W bits.
REQ-016 In INIT, each rising edge with reset low SHALL write reg[cnt] <= 0 and increment cnt.
REQ-017 When cnt == DEPTH-1 in INIT, the same edge SHALL clear the last register and move to RUN; cnt wraps to 0.
REQ-018 ready SHALL be 1 only in RUN; it rises exactly DEPTH edges after the first edge with reset low.
REQ-019 During INIT, wr and claim SHALL be ignored; A, B SHALL read 0; A_busy, B_busy SHALL read 0.
REQ-020 In RUN, wr=1 with a writable address SHALL update reg[wr_register_no] <= wr_data on the rising edge.
REQ-021 If R0_ZERO=1, writes and claims to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and its busy flag SHALL read 0.
REQ-022 Reads SHALL be write-through in RUN: if wr=1, the address is writable and equals A_add (or B_add), then A (or B) SHALL equal wr_data in the same cycle.
REQ-023 Without a bypass hit, A = reg[A_add] and B = reg[B_add].
REQ-024 The scoreboard SHALL hold one busy bit per register, all 0 after reset.
REQ-025 In RUN, claim=1 SHALL set busy[claim_no] on the rising edge; an accepted write SHALL clear busy[wr_register_no].
REQ-026 If claim and write target the same register in the same cycle, claim SHALL win and busy stays 1 (new producer).
REQ-027 A_busy/B_busy SHALL be bypassed: an accepted write to the addressed register forces 0 that cycle, unless a same-cycle claim hits the same register.
REQ-028 Both read ports MAY address the same register; each port SHALL return identical data and busy.
REQ-029 Writing a register that is not busy SHALL still update its data; busy stays 0.

Reset
REQ-030 reset=1 on any edge SHALL force INIT, cnt=0, ready=0 and all busy bits to 0, including mid-INIT or mid-RUN.
REQ-031 Register contents are not guaranteed until INIT completes, which zeroes all DEPTH registers.
REQ-032 wr or claim asserted together with reset SHALL have no effect.

Verification (ADDR_W=5, DATA_W=32, R0_ZERO=1)
REQ-033 Release reset, then count edges -> ready=0 for 31 edges, ready=1 after the 32nd edge; all 32 registers read 0.
REQ-034 In RUN, write r5=0xDEADBEEF with A_add=5 in the same cycle -> A=0xDEADBEEF combinationally; after the edge A still =0xDEADBEEF.
REQ-035 Write r0=0x1234 and claim r0 -> A(A_add=0)=0 and A_busy=0, both in the cycle and after the edge.
REQ-036 Claim r7 -> B_busy=1 after the edge; write r7=0x55 -> B_busy=0 in the same cycle and B=0x55; claim and write r7 together -> busy stays 1.
REQ-037 Assert reset during RUN with r9=0xFF and r9 busy -> busy cleared immediately; after 32 INIT edges r9=0 and ready=1.
REQ-038 Assert wr to r3 during INIT -> write ignored; r3=0 after ready rises.
